// File: rtl/bcd_disp_engine.sv
// Binary-to-seven-segment display engine: assembles a value from byte writes,
// converts it to BCD by double-dabble and drives DIGITS seven-segment digits.
module bcd_disp_engine #(
   parameter int DATA_WIDTH     = 16,
   parameter int DIGITS         = 5,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   input  logic                  frame_start,
   input  logic                  blank_lz,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  busy,
   output logic                  ovf
);

   localparam int NBYTES = (DATA_WIDTH + 7) / 8;
   localparam int SW     = NBYTES * 8;
   localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int CW     = $clog2(DATA_WIDTH + 1);
   localparam int BW     = (DIGITS + 1) * 4;
   localparam int DW4    = DIGITS * 4;
   localparam logic [31:0] OVF_LIMIT = 32'(10 ** DIGITS);

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d, idx_base;
   logic [SW-1:0]          stage_q, stage_d, stage_base, stage_shift;
   logic                   commit;
   logic [DATA_WIDTH-1:0]  commit_val;
   logic                   start;
   logic [DATA_WIDTH-1:0]  start_val;
   logic                   pend_valid_q, pend_valid_d;
   logic [DATA_WIDTH-1:0]  pend_val_q, pend_val_d;
   logic [DATA_WIDTH-1:0]  bin_q, bin_d;
   logic [DATA_WIDTH-1:0]  val_q, val_d;
   logic [BW-1:0]          bcd_q, bcd_d, bcd_adj, bcd_step;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DW4-1:0]         disp_q, disp_d;
   logic                   ovf_q, ovf_d;
   logic [7*DIGITS-1:0]    seg_raw;
   logic [3:0]             dig;
   logic [6:0]             pat;
   logic                   upper_zero;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0111111;
         4'd1:    p = 7'b0000110;
         4'd2:    p = 7'b1011011;
         4'd3:    p = 7'b1001111;
         4'd4:    p = 7'b1100110;
         4'd5:    p = 7'b1101101;
         4'd6:    p = 7'b1111101;
         4'd7:    p = 7'b0000111;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   // frame_start restarts the frame before a same-cycle byte is taken as byte 0
   always_comb begin
      idx_base    = frame_start ? '0 : idx_q;
      stage_base  = frame_start ? '0 : stage_q;
      stage_shift = (stage_base << 8) | SW'(wr_data);
      idx_d       = idx_base;
      stage_d     = stage_base;
      commit      = 1'b0;
      commit_val  = stage_shift[DATA_WIDTH-1:0];
      if (wr_en) begin
         stage_d = stage_shift;
         if (idx_base == IW'(NBYTES - 1)) begin
            commit = 1'b1;
            idx_d  = '0;
         end else begin
            idx_d = idx_base + IW'(1);
         end
      end
   end

   // In LOAD a fresh commit supersedes the pending slot: latest value wins
   always_comb begin
      start     = 1'b0;
      start_val = commit_val;
      case (state_q)
         IDLE: start = commit;
         LOAD: begin
            start = commit | pend_valid_q;
            if (!commit) start_val = pend_val_q;
         end
         default: start = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (commit) state_d = CONV;
         CONV: if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = LOAD;
         LOAD: state_d = start ? CONV : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_step = (bcd_adj << 1) | BW'(bin_q[DATA_WIDTH-1]);
   end

   always_comb begin
      bin_d        = bin_q;
      val_d        = val_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      disp_d       = disp_q;
      ovf_d        = ovf_q;
      pend_valid_d = pend_valid_q;
      pend_val_d   = pend_val_q;
      case (state_q)
         CONV: begin
            bcd_d = bcd_step;
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (commit) begin
               pend_valid_d = 1'b1;
               pend_val_d   = commit_val;
            end
         end
         LOAD: begin
            disp_d       = bcd_q[DW4-1:0];
            ovf_d        = (32'(val_q) >= OVF_LIMIT);
            pend_valid_d = 1'b0;
         end
         default: ;
      endcase
      if (start) begin
         bin_d = start_val;
         val_d = start_val;
         bcd_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q        <= '0;
         stage_q      <= '0;
         pend_valid_q <= 1'b0;
         pend_val_q   <= '0;
         bin_q        <= '0;
         val_q        <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         disp_q       <= '0;
         ovf_q        <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         stage_q      <= stage_d;
         pend_valid_q <= pend_valid_d;
         pend_val_q   <= pend_val_d;
         bin_q        <= bin_d;
         val_q        <= val_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         disp_q       <= disp_d;
         ovf_q        <= ovf_d;
      end
   end

   // Blanking walks down from the top digit; it reads the held BCD value only
   always_comb begin
      seg_raw    = '0;
      upper_zero = 1'b1;
      dig        = '0;
      pat        = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         dig = disp_q[4*i +: 4];
         if (ovf_q)                                          pat = 7'b1000000;
         else if (blank_lz && (i != 0) && upper_zero && (dig == 4'd0)) pat = 7'b0000000;
         else                                                pat = seg_of(dig);
         if (dig != 4'd0) upper_zero = 1'b0;
         seg_raw[7*i +: 7] = pat;
      end
   end

   assign seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_disp_engine.sv
// Scoreboard bench for bcd_disp_engine: two instances (5 and 4 digits) share
// stimulus; a timing/arithmetic model predicts display, busy and ovf each cycle.
module tb_bcd_disp_engine;

   localparam int DW  = 16;
   localparam int NB  = (DW + 7) / 8;
   localparam int LAT = DW + 1;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        frame_start;
   logic        blank_lz;
   logic [34:0] seg5;
   logic [27:0] seg4;
   logic        busy5, busy4, ovf5, ovf4;

   int tests    = 0;
   int failures = 0;
   int edge_cnt = 0;

   typedef struct {
      int start;
      int value;
   } ent_t;

   ent_t sbq[$];
   int   byte_q[$];
   int   last_start = -1000;
   int   cur_val    = 0;

   bcd_disp_engine #(.DATA_WIDTH(DW), .DIGITS(5), .SEG_ACTIVE_LOW(1'b1)) dut5 (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
      .frame_start(frame_start), .blank_lz(blank_lz),
      .seg(seg5), .busy(busy5), .ovf(ovf5)
   );

   bcd_disp_engine #(.DATA_WIDTH(DW), .DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut4 (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
      .frame_start(frame_start), .blank_lz(blank_lz),
      .seg(seg4), .busy(busy4), .ovf(ovf4)
   );

   always #5 clk = ~clk;

   // Edge counter gives every posedge a number for the timing model
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [6:0] digit_pat(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Expected active-low segment bus computed from the decimal value
   function automatic logic [41:0] exp_seg(input int v, input int ndig, input bit blank);
      logic [41:0] r;
      logic [6:0]  pt;
      int lim;
      int p;
      r   = '0;
      lim = 1;
      for (int i = 0; i < ndig; i++) lim = lim * 10;
      p = 1;
      for (int i = 0; i < ndig; i++) begin
         if (v >= lim)                    pt = 7'h40;
         else if (blank && i > 0 && v < p) pt = 7'h00;
         else                             pt = digit_pat((v / p) % 10);
         r[7*i +: 7] = ~pt;
         p = p * 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and feed the byte/commit model
   task automatic applyStimulus(input bit fs, input bit we, input logic [7:0] d);
      int   e;
      int   v;
      int   s;
      ent_t en;
      @(negedge clk);
      frame_start = fs;
      wr_en       = we;
      wr_data     = d;
      e = edge_cnt + 1;
      if (fs) byte_q.delete();
      if (we) begin
         byte_q.push_back(int'(d));
         if (byte_q.size() == NB) begin
            v = 0;
            foreach (byte_q[k]) v = v * 256 + byte_q[k];
            v = v % (1 << DW);
            byte_q.delete();
            if (sbq.size() > 0 && last_start >= e) begin
               sbq[sbq.size()-1].value = v;
            end else begin
               s = (e > last_start + LAT) ? e : last_start + LAT;
               en.start = s;
               en.value = v;
               sbq.push_back(en);
               last_start = s;
            end
         end
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         wr_en       = 1'b0;
         frame_start = 1'b0;
         wr_data     = 8'h00;
      end
   endtask

   task automatic setBlank(input bit b);
      @(negedge clk);
      wr_en       = 1'b0;
      frame_start = 1'b0;
      blank_lz    = b;
   endtask

   task automatic doReset();
      logic [41:0] e;
      @(negedge clk);
      wr_en       = 1'b0;
      frame_start = 1'b0;
      wr_data     = 8'h00;
      #2 rstn = 1'b0;
      sbq.delete();
      byte_q.delete();
      last_start = -1000;
      cur_val    = 0;
      #1;
      e = exp_seg(0, 5, blank_lz);
      checkOutput("rst_seg5", 64'(seg5), 64'(e[34:0]));
      e = exp_seg(0, 4, blank_lz);
      checkOutput("rst_seg4", 64'(seg4), 64'(e[27:0]));
      checkOutput("rst_busy", 64'({busy5, busy4}), 64'(0));
      checkOutput("rst_ovf", 64'({ovf5, ovf4}), 64'(0));
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   // Monitor: retire conversions whose display time has come, then compare
   initial begin
      logic [41:0] e5;
      logic [41:0] e4;
      int          c;
      bit          eb;
      forever begin
         @(posedge clk);
         #1;
         c = edge_cnt;
         while (sbq.size() > 0 && sbq[0].start + LAT <= c) begin
            cur_val = sbq[0].value;
            void'(sbq.pop_front());
         end
         eb = (sbq.size() > 0) && (sbq[0].start <= c);
         e5 = exp_seg(cur_val, 5, blank_lz);
         e4 = exp_seg(cur_val, 4, blank_lz);
         checkOutput($sformatf("seg5@%0d", c), 64'(seg5), 64'(e5[34:0]));
         checkOutput($sformatf("seg4@%0d", c), 64'(seg4), 64'(e4[27:0]));
         checkOutput($sformatf("busy5@%0d", c), 64'(busy5), 64'(eb));
         checkOutput($sformatf("busy4@%0d", c), 64'(busy4), 64'(eb));
         checkOutput($sformatf("ovf5@%0d", c), 64'(ovf5), 64'(cur_val >= 100000));
         checkOutput($sformatf("ovf4@%0d", c), 64'(ovf4), 64'(cur_val >= 10000));
      end
   end

   initial begin
      int          v;
      logic [15:0] vv;
      rstn        = 1'b1;
      wr_en       = 1'b0;
      wr_data     = 8'h00;
      frame_start = 1'b0;
      blank_lz    = 1'b0;
      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      idleCycles(2);

      // 12345, then 10000 (overflows 4 digits), then 9999
      applyStimulus(0, 1, 8'h30); applyStimulus(0, 1, 8'h39); idleCycles(20);
      applyStimulus(0, 1, 8'h27); applyStimulus(0, 1, 8'h10); idleCycles(20);
      applyStimulus(0, 1, 8'h27); applyStimulus(0, 1, 8'h0F); idleCycles(20);

      // Leading-zero blanking on 7, then toggled without reconversion
      setBlank(1'b1);
      applyStimulus(0, 1, 8'h00); applyStimulus(0, 1, 8'h07); idleCycles(20);
      setBlank(1'b0); idleCycles(3); setBlank(1'b1); idleCycles(2);

      // 100, 200, 300 committed two cycles apart
      applyStimulus(0, 1, 8'h00); applyStimulus(0, 1, 8'h64);
      applyStimulus(0, 1, 8'h00); applyStimulus(0, 1, 8'hC8);
      applyStimulus(0, 1, 8'h01); applyStimulus(0, 1, 8'h2C);
      idleCycles(45);

      // Resync with a lone frame_start, then with frame_start plus a byte
      applyStimulus(0, 1, 8'h12); applyStimulus(1, 0, 8'h00);
      applyStimulus(0, 1, 8'h00); applyStimulus(0, 1, 8'h2A); idleCycles(20);
      applyStimulus(0, 1, 8'h99); applyStimulus(1, 1, 8'h03);
      applyStimulus(0, 1, 8'hE8); idleCycles(20);

      // Reset in the middle of a conversion and of a frame
      applyStimulus(0, 1, 8'h04); applyStimulus(0, 1, 8'hD2); idleCycles(4);
      applyStimulus(0, 1, 8'h55); idleCycles(2);
      doReset();
      idleCycles(2);
      applyStimulus(0, 1, 8'h00); applyStimulus(0, 1, 8'h05); idleCycles(20);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 65535));
            1:       v = int'($urandom_range(9990, 10010));
            2:       v = int'($urandom_range(0, 20));
            default: v = int'($urandom_range(0, 65535));
         endcase
         vv = 16'(v);
         if ($urandom_range(0, 5) == 0) setBlank(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) applyStimulus(1, 0, 8'h00);
         if ($urandom_range(0, 6) == 0) begin
            applyStimulus(0, 1, 8'($urandom));
            applyStimulus(1, 1, vv[15:8]);
         end else begin
            applyStimulus(0, 1, vv[15:8]);
         end
         if ($urandom_range(0, 4) == 0) idleCycles(int'($urandom_range(1, 3)));
         applyStimulus(0, 1, vv[7:0]);
         idleCycles(int'($urandom_range(0, 24)));
      end

      for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
      checkOutput("drain", 64'(sbq.size()), 64'(0));
      idleCycles(3);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
